// File: rtl/memory_loader_pkg.sv
// Shared definitions for the memory loader: bus/address sizing and the
// loader FSM state encoding. The VERIFY state only exists when the
// read-back check is built in (LOADER_VERIFY_EN).
package loader_pkg;

    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 16;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_SET_ADDR  = 3'd2,
        ST_WRITE     = 3'd3,
`ifdef LOADER_VERIFY_EN
        ST_VERIFY    = 3'd4,
`endif
        ST_FINISH    = 3'd5
    } state_e;

endpackage

// File: rtl/memory_loader_if.sv
// Handshake and memory-bus signals between a host and the memory loader.
// master: host side (requests loads, streams bytes, returns memory read data).
// slave:  loader side (drives address strobe, write enable and the bus).
interface memory_loader_if #(
    parameter int DATA_W = loader_pkg::DATA_W,
    parameter int ADDR_W = loader_pkg::ADDR_W
);
    logic              start;
    logic [ADDR_W-1:0] load_len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [DATA_W-1:0] mem_out;
    logic              mi;
    logic              we;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, load_len, in_valid, in_data, mem_out,
        input  in_ready, mi, we, bus_out, bus_oe, busy, done, err
    );

    modport slave (
        input  start, load_len, in_valid, in_data, mem_out,
        output in_ready, mi, we, bus_out, bus_oe, busy, done, err
    );
endinterface

// File: rtl/memory_loader.sv
// Memory loader: accepts a stream of bytes and writes them to consecutive
// memory addresses starting at 0, using a two-step bus protocol (address
// strobe mi, then write strobe we). Optional read-back check of each byte
// is enabled by defining LOADER_VERIFY_EN; without it err is tied low and
// mem_out is ignored.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | waiting for start; all outputs low
// WAIT_DATA  | in_ready high; next byte captured into data_q
// SET_ADDR   | drive address counter on bus, pulse mi
// WRITE      | drive captured byte on bus, pulse we
// VERIFY     | (LOADER_VERIFY_EN) compare mem_out with data_q
// FINISH     | one-cycle done pulse, back to IDLE
module memory_loader
    import loader_pkg::*;
#(
    parameter int DATA_W    = loader_pkg::DATA_W,
    parameter int MEM_DEPTH = loader_pkg::MEM_DEPTH
) (
    input logic            clk,
    input logic            rst,
    memory_loader_if.slave lb
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              mi_c;
    logic              we_c;
    logic              bus_oe_c;
    logic              in_ready_c;
    logic              done_c;
    logic [DATA_W-1:0] bus_out_c;

`ifdef LOADER_VERIFY_EN
    logic err_q, err_d;
`endif

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_cnt_q <= '0;
            len_q      <= '0;
            data_q     <= '0;
`ifdef LOADER_VERIFY_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            len_q      <= len_d;
            data_q     <= data_d;
`ifdef LOADER_VERIFY_EN
            err_q      <= err_d;
`endif
        end
    end

    // Next-state, counter update and state-decoded outputs
    always_comb begin
        state_d    = state_q;
        addr_cnt_d = addr_cnt_q;
        len_d      = len_q;
        data_d     = data_q;
`ifdef LOADER_VERIFY_EN
        err_d      = err_q;
`endif
        mi_c       = 1'b0;
        we_c       = 1'b0;
        bus_oe_c   = 1'b0;
        in_ready_c = 1'b0;
        done_c     = 1'b0;
        bus_out_c  = '0;

        case (state_q)
            ST_IDLE: begin
                if (lb.start) begin
                    len_d      = lb.load_len;
                    addr_cnt_d = '0;
`ifdef LOADER_VERIFY_EN
                    err_d      = 1'b0;
`endif
                    state_d    = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                in_ready_c = 1'b1;
                if (lb.in_valid) begin
                    data_d  = lb.in_data;
                    state_d = ST_SET_ADDR;
                end
            end
            ST_SET_ADDR: begin
                bus_oe_c  = 1'b1;
                mi_c      = 1'b1;
                bus_out_c = DATA_W'(addr_cnt_q);
                state_d   = ST_WRITE;
            end
            ST_WRITE: begin
                bus_oe_c  = 1'b1;
                we_c      = 1'b1;
                bus_out_c = data_q;
`ifdef LOADER_VERIFY_EN
                state_d   = ST_VERIFY;
`else
                // last address finishes without bumping the counter, so it never wraps
                if (addr_cnt_q == len_q) begin
                    state_d = ST_FINISH;
                end else begin
                    addr_cnt_d = addr_cnt_q + 1'b1;
                    state_d    = ST_WAIT_DATA;
                end
`endif
            end
`ifdef LOADER_VERIFY_EN
            ST_VERIFY: begin
                if (lb.mem_out != data_q) begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end else if (addr_cnt_q == len_q) begin
                    state_d = ST_FINISH;
                end else begin
                    addr_cnt_d = addr_cnt_q + 1'b1;
                    state_d    = ST_WAIT_DATA;
                end
            end
`endif
            ST_FINISH: begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign lb.mi       = mi_c;
    assign lb.we       = we_c;
    assign lb.bus_oe   = bus_oe_c;
    assign lb.bus_out  = bus_out_c;
    assign lb.in_ready = in_ready_c;
    assign lb.done     = done_c;
    assign lb.busy     = (state_q != ST_IDLE);
`ifdef LOADER_VERIFY_EN
    assign lb.err      = err_q;
`else
    assign lb.err      = 1'b0;
`endif

endmodule
